// File: rtl/phy_tx_lanes.sv
// phy_tx_lanes: multi-lane PHY transmit serialiser.
// Captures all lanes once per frame and shifts them out MSB-first, one bit per clock.
module phy_tx_lanes #(
    parameter int LANES       = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_FRAMES = 2
) (
    input  logic                                    clk_32f,
    input  logic                                    rst,
    input  logic [LANES*WIDTH-1:0]                  in_data,
    input  logic [LANES-1:0]                        valid_in,
    input  logic [LANES-1:0]                        lane_mask,
    input  logic [WIDTH-1:0]                        IDLE,
    output logic                                    sample_stb,
    output logic                                    salida_tx,
    output logic                                    tx_active,
    output logic [((LANES>1)?$clog2(LANES):1)-1:0]  lane_idx,
    output logic                                    sync_done
);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW  = $clog2(WIDTH);
    localparam int FCW = (SYNC_FRAMES > 0) ? $clog2(SYNC_FRAMES + 1) : 1;

    localparam logic [LIW-1:0] LANE_LAST = LIW'(LANES - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [FCW-1:0] FRM_LAST  =
        FCW'((SYNC_FRAMES > 0) ? SYNC_FRAMES - 1 : 0);
    localparam logic [FCW-1:0] FRM_MAX   = FCW'(SYNC_FRAMES);
    localparam state_t         ST_INIT   =
        (SYNC_FRAMES > 0) ? ST_SYNC : ST_RUN;

    state_t                   state_q, state_d;
    logic                     started_q, started_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [LIW-1:0]           lane_cnt_q, lane_cnt_d;
    logic [FCW-1:0]           frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0]         shreg_q, shreg_d;
    logic                     tx_q, tx_d;
    logic                     act_q, act_d;
    logic [LIW-1:0]           idx_q, idx_d;
    logic                     done_q, done_d;
    logic [LANES*WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [LANES-1:0]         hold_use_q, hold_use_d;
    logic [WIDTH-1:0]         hold_idle_q, hold_idle_d;

    logic                     last_slot;
    logic                     word_end;
    logic                     boundary;
    logic                     frame_end;
    logic                     load;
    logic                     ld_use;
    logic [WIDTH-1:0]         ld_word;
    logic [LIW-1:0]           nxt_lane;

    // Slot counters, sync state machine, frame capture and word load/shift
    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        bit_cnt_d   = bit_cnt_q;
        lane_cnt_d  = lane_cnt_q;
        frame_cnt_d = frame_cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        act_d       = act_q;
        idx_d       = idx_q;
        done_d      = done_q;
        hold_data_d = hold_data_q;
        hold_use_d  = hold_use_q;
        hold_idle_d = hold_idle_q;
        load        = 1'b0;
        ld_use      = 1'b0;
        ld_word     = hold_idle_q;
        nxt_lane    = lane_cnt_q + 1'b1;

        word_end  = (bit_cnt_q == BIT_LAST);
        last_slot = word_end && (lane_cnt_q == LANE_LAST);
        boundary  = !started_q || last_slot;
        frame_end = started_q && last_slot;

        if (frame_end && state_q == ST_SYNC) begin
            if (frame_cnt_q != FRM_MAX) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (frame_cnt_q == FRM_LAST) begin
                state_d = ST_RUN;
            end
        end

        sample_stb = frame_end && (state_d == ST_RUN);

        if (started_q) begin
            if (word_end) begin
                bit_cnt_d  = '0;
                lane_cnt_d = (lane_cnt_q == LANE_LAST) ? '0 : nxt_lane;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (boundary) begin
            hold_data_d = in_data;
            hold_idle_d = IDLE;
            hold_use_d  = (state_d == ST_RUN) ? (valid_in & lane_mask) : '0;
            ld_use      = hold_use_d[0];
            ld_word     = ld_use ? in_data[WIDTH-1:0] : IDLE;
            idx_d       = '0;
            done_d      = (state_d == ST_RUN);
            load        = 1'b1;
        end else if (word_end) begin
            for (int k = 0; k < LANES; k++) begin
                if (nxt_lane == LIW'(k)) begin
                    ld_use  = hold_use_q[k];
                    ld_word = hold_use_q[k] ?
                              hold_data_q[k*WIDTH +: WIDTH] : hold_idle_q;
                end
            end
            idx_d = nxt_lane;
            load  = 1'b1;
        end

        if (load) begin
            tx_d    = ld_word[WIDTH-1];
            shreg_d = {ld_word[WIDTH-2:0], 1'b0};
            act_d   = ld_use;
        end else begin
            tx_d    = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            started_q   <= 1'b0;
            bit_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            frame_cnt_q <= '0;
            shreg_q     <= '0;
            tx_q        <= 1'b0;
            act_q       <= 1'b0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            hold_data_q <= '0;
            hold_use_q  <= '0;
            hold_idle_q <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            bit_cnt_q   <= bit_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            act_q       <= act_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            hold_data_q <= hold_data_d;
            hold_use_q  <= hold_use_d;
            hold_idle_q <= hold_idle_d;
        end
    end

    assign salida_tx = tx_q;
    assign tx_active = act_q;
    assign lane_idx  = idx_q;
    assign sync_done = done_q;

endmodule

// File: tb/tb_phy_tx_lanes.sv
// tb_phy_tx_lanes: directed bench for the multi-lane PHY serialiser.
// Covers sync frames, data frames, masking, mid-frame changes, reset, single lane.
module tb_phy_tx_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  valid_in;
    logic [3:0]  lane_mask;
    logic [7:0]  idle;
    logic        sample_stb;
    logic        salida_tx;
    logic        tx_active;
    logic [1:0]  lane_idx;
    logic        sync_done;

    logic        rst1;
    logic [9:0]  d1;
    logic [0:0]  v1;
    logic [0:0]  m1;
    logic [9:0]  idle1;
    logic        stb1;
    logic        tx1;
    logic        act1;
    logic [0:0]  idx1;
    logic        done1;

    int checks = 0;
    int errors = 0;

    phy_tx_lanes #(.LANES(4), .WIDTH(8), .SYNC_FRAMES(2)) u0 (
        .clk_32f   (clk),
        .rst       (rst),
        .in_data   (in_data),
        .valid_in  (valid_in),
        .lane_mask (lane_mask),
        .IDLE      (idle),
        .sample_stb(sample_stb),
        .salida_tx (salida_tx),
        .tx_active (tx_active),
        .lane_idx  (lane_idx),
        .sync_done (sync_done)
    );

    phy_tx_lanes #(.LANES(1), .WIDTH(10), .SYNC_FRAMES(0)) u1 (
        .clk_32f   (clk),
        .rst       (rst1),
        .in_data   (d1),
        .valid_in  (v1),
        .lane_mask (m1),
        .IDLE      (idle1),
        .sample_stb(stb1),
        .salida_tx (tx1),
        .tx_active (act1),
        .lane_idx  (idx1),
        .sync_done (done1)
    );

    task automatic test_reset();
        #1;
        checks++;
        if ({salida_tx, sample_stb, tx_active, lane_idx, sync_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {salida_tx, sample_stb, tx_active, lane_idx, sync_done});
        end
        checks++;
        if ({tx1, stb1, act1, idx1, done1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_1lane got %b want 00000",
                     {tx1, stb1, act1, idx1, done1});
        end
    endtask

    task automatic test_sync(input string tag);
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            checks++;
            if (salida_tx !== idle[7-(c%8)]) begin
                errors++;
                $display("FAIL %s_bit c=%0d got %b want %b",
                         tag, c, salida_tx, idle[7-(c%8)]);
            end
            checks++;
            if (tx_active !== 1'b0 || sync_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_flags c=%0d act=%b done=%b want 0 0",
                         tag, c, tx_active, sync_done);
            end
            checks++;
            if (sample_stb !== (c == 63)) begin
                errors++;
                $display("FAIL %s_stb c=%0d got %b want %b",
                         tag, c, sample_stb, (c == 63));
            end
            checks++;
            if (lane_idx !== 2'((c/8)%4)) begin
                errors++;
                $display("FAIL %s_idx c=%0d got %0d want %0d",
                         tag, c, lane_idx, (c/8)%4);
            end
        end
    endtask

    task automatic test_run_data(input string tag, input logic [31:0] data,
                                 input logic [31:0] exp);
        in_data   = data;
        valid_in  = 4'hF;
        lane_mask = 4'hF;
        checks++;
        if (sample_stb !== 1'b1) begin
            errors++;
            $display("FAIL %s_prestb got %b want 1", tag, sample_stb);
        end
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            checks++;
            if (salida_tx !== exp[31-c]) begin
                errors++;
                $display("FAIL %s_bit c=%0d got %b want %b",
                         tag, c, salida_tx, exp[31-c]);
            end
            checks++;
            if (tx_active !== 1'b1 || sync_done !== 1'b1) begin
                errors++;
                $display("FAIL %s_flags c=%0d act=%b done=%b want 1 1",
                         tag, c, tx_active, sync_done);
            end
            checks++;
            if (lane_idx !== 2'(c/8) || sample_stb !== (c == 31)) begin
                errors++;
                $display("FAIL %s_idx_stb c=%0d idx=%0d stb=%b want %0d %b",
                         tag, c, lane_idx, sample_stb, c/8, (c == 31));
            end
        end
    endtask

    task automatic test_valid_mask();
        logic [3:0]  tv [4];
        logic [3:0]  tm [4];
        logic [31:0] te [4];
        logic [3:0]  ta [4];
        tv[0] = 4'b1010; tm[0] = 4'hF;    te[0] = 32'hBCFFBC3C; ta[0] = 4'b1010;
        tv[1] = 4'hF;    tm[1] = 4'b0111; te[1] = 32'hA5FF0FBC; ta[1] = 4'b0111;
        tv[2] = 4'hF;    tm[2] = 4'b0000; te[2] = 32'hBCBCBCBC; ta[2] = 4'b0000;
        tv[3] = 4'b0000; tm[3] = 4'hF;    te[3] = 32'hBCBCBCBC; ta[3] = 4'b0000;
        in_data = 32'h3C0FFFA5;
        for (int t = 0; t < 4; t++) begin
            valid_in  = tv[t];
            lane_mask = tm[t];
            checks++;
            if (sample_stb !== 1'b1) begin
                errors++;
                $display("FAIL vm%0d_prestb got %b want 1", t, sample_stb);
            end
            for (int c = 0; c < 32; c++) begin
                @(posedge clk); #1;
                checks++;
                if (salida_tx !== te[t][31-c]) begin
                    errors++;
                    $display("FAIL vm%0d_bit c=%0d got %b want %b",
                             t, c, salida_tx, te[t][31-c]);
                end
                checks++;
                if (tx_active !== ta[t][c/8]) begin
                    errors++;
                    $display("FAIL vm%0d_act c=%0d got %b want %b",
                             t, c, tx_active, ta[t][c/8]);
                end
                checks++;
                if (sample_stb !== (c == 31) || lane_idx !== 2'(c/8)) begin
                    errors++;
                    $display("FAIL vm%0d_stb_idx c=%0d stb=%b idx=%0d want %b %0d",
                             t, c, sample_stb, lane_idx, (c == 31), c/8);
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [31:0] exp;
        in_data   = 32'h12345678;
        valid_in  = 4'hF;
        lane_mask = 4'hF;
        checks++;
        if (sample_stb !== 1'b1) begin
            errors++;
            $display("FAIL mid_prestb got %b want 1", sample_stb);
        end
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            exp = (c < 32) ? 32'h78563412 : 32'hEFBEADDE;
            checks++;
            if (salida_tx !== exp[31-(c%32)]) begin
                errors++;
                $display("FAIL mid_bit c=%0d got %b want %b",
                         c, salida_tx, exp[31-(c%32)]);
            end
            checks++;
            if (sample_stb !== ((c%32) == 31)) begin
                errors++;
                $display("FAIL mid_stb c=%0d got %b want %b",
                         c, sample_stb, ((c%32) == 31));
            end
            if (c == 10) in_data = 32'hDEADBEEF;
        end
    endtask

    task automatic test_reset_midframe();
        checks++;
        if (sample_stb !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_prestb got %b want 1", sample_stb);
        end
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tx_active !== 1'b1 || lane_idx !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_pre act=%b idx=%0d want 1 1", tx_active, lane_idx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({salida_tx, sample_stb, tx_active, lane_idx, sync_done} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got %b want 000000",
                     {salida_tx, sample_stb, tx_active, lane_idx, sync_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_sync("resync");
        test_run_data("postsync", 32'hDEADBEEF, 32'hEFBEADDE);
    endtask

    task automatic test_single_lane();
        logic [9:0] w;
        d1    = 10'h2B5;
        v1    = 1'b1;
        m1    = 1'b1;
        idle1 = 10'h17C;
        @(negedge clk);
        rst1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            w = (c < 20) ? 10'h2B5 : 10'h0F3;
            checks++;
            if (tx1 !== w[9-(c%10)]) begin
                errors++;
                $display("FAIL one_bit c=%0d got %b want %b", c, tx1, w[9-(c%10)]);
            end
            checks++;
            if (stb1 !== ((c%10) == 9)) begin
                errors++;
                $display("FAIL one_stb c=%0d got %b want %b", c, stb1, ((c%10) == 9));
            end
            checks++;
            if (act1 !== 1'b1 || idx1 !== 1'b0 || done1 !== 1'b1) begin
                errors++;
                $display("FAIL one_flags c=%0d act=%b idx=%b done=%b want 1 0 1",
                         c, act1, idx1, done1);
            end
            if (c == 15) d1 = 10'h0F3;
        end
    endtask

    initial begin
        rst       = 1'b0;
        rst1      = 1'b0;
        in_data   = 32'h3C0FFFA5;
        valid_in  = 4'hF;
        lane_mask = 4'hF;
        idle      = 8'hBC;
        d1        = '0;
        v1        = 1'b0;
        m1        = 1'b0;
        idle1     = '0;
        test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_sync("sync");
        test_run_data("run", 32'h3C0FFFA5, 32'hA5FF0F3C);
        test_valid_mask();
        test_midframe_change();
        test_reset_midframe();
        test_single_lane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
